// File: rtl/dff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_chk_pkg
// Description : Shared definitions for the dff_resp_checker slice: the
//               checker FSM state encoding and a saturating increment helper.
// Revision    : 1.0  initial release
// ============================================================================
package dff_chk_pkg;

   // Checker FSM states (2-bit encoding).
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Increment that sticks at max_val instead of wrapping.
   // Callers size-cast their operands to 32 bits, so counters up to 32 bits wide are supported.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val == max_val) ? val : val + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dff_chk_delay.sv
`default_nettype none
// ============================================================================
// Module      : dff_chk_delay
// Description : Enable-gated delay line of LATENCY stages, each carrying a
//               valid bit and WIDTH data bits. Stage 0 loads {1, din} when
//               en=1; every stage holds when en=0. flush clears all stages
//               synchronously and takes priority over en.
// Ports       : clk, rst (async, active-high), flush, en, din[WIDTH]
//               -> tail_vld, tail_data[WIDTH] (oldest stage)
// Revision    : 1.0  initial release
// ============================================================================
module dff_chk_delay #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic             tail_vld,
   output logic [WIDTH-1:0] tail_data
);

   logic [LATENCY-1:0] stage_vld;
   logic [WIDTH-1:0]   stage_data [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_vld[i]  <= 1'b0;
            stage_data[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_vld[i]  <= 1'b0;
            stage_data[i] <= '0;
         end
      end else if (en) begin
         stage_vld[0]  <= 1'b1;
         stage_data[0] <= din;
         for (int i = 1; i < LATENCY; i++) begin
            stage_vld[i]  <= stage_vld[i-1];
            stage_data[i] <= stage_data[i-1];
         end
      end
   end

   assign tail_vld  = stage_vld[LATENCY-1];
   assign tail_data = stage_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/dff_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : dff_resp_checker
// Description : On-chip response checker for a single-clock register path.
//               Predicts resp as stim delayed by LATENCY en-qualified cycles,
//               pulses mismatch the cycle after a failed compare, keeps a
//               saturating error count and reports pass/fail when a run ends.
// Ports       : clk, rst (async, active-high), start, stop, en,
//               stim[WIDTH], resp[WIDTH]
//               -> busy, done, pass, mismatch, err_cnt[CNT_W], err_sat
//               (+ first_idx, first_exp, first_got, first_vld when
//               DFF_CHK_FIRSTERR_EN is defined)
// Options     : DFF_CHK_FIRSTERR_EN - capture index/expected/observed value
//               of the first mismatch of each run.
// Revision    : 1.0  initial release
// ============================================================================
module dff_resp_checker
   import dff_chk_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic [WIDTH-1:0] stim,
   input  logic [WIDTH-1:0] resp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sat
`ifdef DFF_CHK_FIRSTERR_EN
   ,
   output logic [CNT_W-1:0] first_idx,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got,
   output logic             first_vld
`endif
);

   localparam int                FILL_W    = (LATENCY < 2) ? 1 : $clog2(LATENCY);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t              state_q;
   state_t              state_d;
   logic [FILL_W-1:0]   fill_cnt;
   logic                tail_vld;
   logic [WIDTH-1:0]    tail_data;
   logic                start_run;
   logic                stop_run;
   logic                cmp;
   logic                miss;
   logic [CNT_W-1:0]    err_next;

   // start is only honoured from IDLE/DONE, stop only while a run is active;
   // the two sets of states are disjoint, which resolves a simultaneous start+stop.
   assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign stop_run  = stop  && ((state_q == ST_FILL) || (state_q == ST_CHECK));

   // Compare only once the delay line holds LATENCY real samples, so the DUT's
   // reset value is never judged. A stop cycle still compares.
   assign cmp      = (state_q == ST_CHECK) && en && tail_vld;
   assign miss     = cmp && (resp != tail_data);
   assign err_next = miss ? CNT_W'(sat_inc(32'(err_cnt), 32'(CNT_MAX))) : err_cnt;

   dff_chk_delay #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .flush     (start_run),
      .en        (en),
      .din       (stim),
      .tail_vld  (tail_vld),
      .tail_data (tail_data)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (stop)                             state_d = ST_DONE;
            else if (en && (fill_cnt == FILL_LAST)) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (stop) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_FILL) || (state_q == ST_CHECK);
   assign done = (state_q == ST_DONE);

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt <= '0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         err_sat  <= 1'b0;
         pass     <= 1'b0;
      end else begin
         mismatch <= miss;
         if (start_run) begin
            fill_cnt <= '0;
            err_cnt  <= '0;
            err_sat  <= 1'b0;
            pass     <= 1'b0;
         end else begin
            if ((state_q == ST_FILL) && en) fill_cnt <= fill_cnt + FILL_W'(1);
            err_cnt <= err_next;
            if (miss && (err_next == CNT_MAX)) err_sat <= 1'b1;
            // pass reflects the count including the compare made on the stop cycle.
            if (stop_run) pass <= (err_next == '0);
         end
      end
   end

`ifdef DFF_CHK_FIRSTERR_EN
   // ------------------------------------------------ first-error capture
   logic [CNT_W-1:0] cmp_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_idx   <= '0;
         first_idx <= '0;
         first_exp <= '0;
         first_got <= '0;
         first_vld <= 1'b0;
      end else if (start_run) begin
         cmp_idx   <= '0;
         first_idx <= '0;
         first_exp <= '0;
         first_got <= '0;
         first_vld <= 1'b0;
      end else begin
         if (cmp) cmp_idx <= cmp_idx + CNT_W'(1);
         if (miss && !first_vld) begin
            first_idx <= cmp_idx;
            first_exp <= tail_data;
            first_got <= resp;
            first_vld <= 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
